// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for a 5-stage pipeline (IF/ID, ID/EX,
// EX/MEM, MEM/WB registers plus PC hold). A register is never stalled and
// flushed in the same cycle.
//
// Hazard sources: load-use in ID, taken branch in EX, multi-cycle MDU op,
// data-memory wait (with timeout).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs/id_rt, id_use_*    ID-stage source registers and their use flags
//   ex_rd, ex_is_load        EX-stage destination and load flag
//   ex_br_taken              EX branch/jump resolved taken
//   ex_mdu_start             EX issues a mul/div
//   mem_req, mem_ready       MEM-stage data access and its completion
//   pc_stall, pc_redirect    PC hold / load branch target
//   stall_*, flush_*         per pipeline-register stall and bubble
//   mdu_done                 one-cycle pulse, MDU result valid
//   mem_err                  one-cycle pulse, memory timeout
//   state                    00 RUN, 01 MDU, 10 MEM
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REGW    = 5,
  parameter int MDU_LAT = 4,
  parameter int CNTW    = 3,
  parameter int MEM_TO  = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] id_rs,
  input  logic            id_use_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_use_rt,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_is_load,
  input  logic            ex_br_taken,
  input  logic            ex_mdu_start,
  input  logic            mem_req,
  input  logic            mem_ready,
  output logic            pc_stall,
  output logic            pc_redirect,
  output logic            stall_ifid,
  output logic            stall_idex,
  output logic            stall_exmem,
  output logic            stall_memwb,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            flush_exmem,
  output logic            flush_memwb,
  output logic            mdu_done,
  output logic            mem_err,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    ST_RUN = 2'b00,
    ST_MDU = 2'b01,
    ST_MEM = 2'b10
  } state_t;

  localparam int MW = (MEM_TO > 1) ? $clog2(MEM_TO) : 1;
  localparam logic [MW-1:0]   MEM_LAST = MW'(MEM_TO - 1);
  // Counter preload is only meaningful when the MDU actually stalls.
  localparam logic [CNTW-1:0] MDU_INIT = CNTW'((MDU_LAT > 1) ? MDU_LAT - 2 : 0);

  state_t          cur_state, nxt_state;
  logic [CNTW-1:0] mdu_cnt, mdu_cnt_nxt;
  logic [MW-1:0]   mem_cnt, mem_cnt_nxt;
  logic            load_use;

  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_use_rs && (id_rs == ex_rd)) ||
                     (id_use_rt && (id_rt == ex_rd)));

  assign state = cur_state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_RUN;
      mdu_cnt   <= '0;
      mem_cnt   <= '0;
    end else begin
      cur_state <= nxt_state;
      mdu_cnt   <= mdu_cnt_nxt;
      mem_cnt   <= mem_cnt_nxt;
    end
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no
    // path through the case below can leave one unassigned (no latches).
    nxt_state   = cur_state;
    mdu_cnt_nxt = mdu_cnt;
    mem_cnt_nxt = mem_cnt;
    pc_stall    = 1'b0;
    pc_redirect = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    stall_memwb = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    mdu_done    = 1'b0;
    mem_err     = 1'b0;

    if (!rst) begin
      unique case (cur_state)
        ST_RUN: begin
          if (mem_req && !mem_ready) begin
            // Memory wait outranks everything: freeze up to EX/MEM, bubble WB.
            nxt_state   = ST_MEM;
            mem_cnt_nxt = '0;
            pc_stall    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            flush_memwb = 1'b1;
          end else if (ex_mdu_start && (MDU_LAT > 1)) begin
            nxt_state   = ST_MDU;
            mdu_cnt_nxt = MDU_INIT;
            pc_stall    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            flush_memwb = 1'b1;
          end else begin
            // Single-cycle MDU completes in place; pipeline keeps flowing.
            mdu_done = ex_mdu_start;
            if (ex_br_taken) begin
              // Wrong-path instructions in IF and ID die; a load-use stall
              // on a dead ID instruction would be pointless.
              pc_redirect = 1'b1;
              flush_ifid  = 1'b1;
              flush_idex  = 1'b1;
            end else if (load_use) begin
              pc_stall   = 1'b1;
              stall_ifid = 1'b1;
              flush_idex = 1'b1;
            end
          end
        end

        ST_MDU: begin
          if (mdu_cnt == '0) begin
            mdu_done  = 1'b1;
            nxt_state = ST_RUN;
          end else begin
            mdu_cnt_nxt = mdu_cnt - CNTW'(1);
            pc_stall    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            flush_memwb = 1'b1;
          end
        end

        ST_MEM: begin
          if (mem_ready) begin
            nxt_state = ST_RUN;
          end else if (mem_cnt == MEM_LAST) begin
            // Timeout: kill the stuck access instead of holding it.
            mem_err     = 1'b1;
            nxt_state   = ST_RUN;
            pc_stall    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            flush_exmem = 1'b1;
            flush_memwb = 1'b1;
          end else begin
            mem_cnt_nxt = mem_cnt + MW'(1);
            pc_stall    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            flush_memwb = 1'b1;
          end
        end

        default: nxt_state = ST_RUN;
      endcase
    end
  end

  a_no_stall_and_flush: assert property (@(posedge clk)
    !((stall_ifid && flush_ifid) || (stall_idex && flush_idex) ||
      (stall_exmem && flush_exmem) || (stall_memwb && flush_memwb)));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl (defaults MDU_LAT=4, MEM_TO=15).
// Inputs change just after the falling edge; outputs are compared one time
// unit later, well before the next rising edge.
// Output vector order: {pc_stall, pc_redirect, stall ifid/idex/exmem/memwb,
// flush ifid/idex/exmem/memwb, mdu_done, mem_err}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam logic [11:0] O_NONE   = 12'b0_0_0000_0000_00;
  localparam logic [11:0] O_LU     = 12'b1_0_1000_0100_00;
  localparam logic [11:0] O_BR     = 12'b0_1_0000_1100_00;
  localparam logic [11:0] O_FREEZE = 12'b1_0_1110_0001_00;
  localparam logic [11:0] O_DONE   = 12'b0_0_0000_0000_10;
  localparam logic [11:0] O_ERR    = 12'b1_0_1100_0011_01;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_is_load, ex_br_taken, ex_mdu_start;
  logic       mem_req, mem_ready;
  logic       pc_stall, pc_redirect;
  logic       stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic       flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic       mdu_done, mem_err;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_use_rs(id_use_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .ex_mdu_start(ex_mdu_start), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .pc_redirect(pc_redirect),
    .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .flush_memwb(flush_memwb),
    .mdu_done(mdu_done), .mem_err(mem_err), .state(state)
  );

  wire [11:0] outs = {pc_stall, pc_redirect,
                      stall_ifid, stall_idex, stall_exmem, stall_memwb,
                      flush_ifid, flush_idex, flush_exmem, flush_memwb,
                      mdu_done, mem_err};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Compare outputs (and state) for the current cycle, then advance one cycle.
  task automatic cyc(input string tag, input logic [11:0] eo, input logic [1:0] es);
    #1;
    check({tag, " outs"}, {4'b0, outs}, {4'b0, eo});
    check({tag, " state"}, {14'b0, state}, {14'b0, es});
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 0; id_use_rt = 0; ex_is_load = 0;
    ex_br_taken = 0; ex_mdu_start = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    // Hazard-looking inputs during reset must still produce all-zero outputs.
    mem_req = 1; ex_br_taken = 1; ex_mdu_start = 1;
    cyc("reset", O_NONE, 2'b00);
    idle_inputs();
    rst = 0;
    cyc("idle", O_NONE, 2'b00);

    // 1: lw r3 in EX, add r4,r3,r5 in ID -> one-cycle load-use stall.
    ex_is_load = 1; ex_rd = 5'd3; id_rs = 5'd3; id_rt = 5'd5;
    id_use_rs = 1; id_use_rt = 1;
    cyc("lu_rs", O_LU, 2'b00);
    ex_is_load = 0; ex_rd = 5'd0;
    cyc("lu_after", O_NONE, 2'b00);
    // Match through rt only.
    ex_is_load = 1; ex_rd = 5'd7; id_rs = 5'd1; id_rt = 5'd7;
    cyc("lu_rt", O_LU, 2'b00);
    // rs matches but is not read.
    id_use_rs = 0; id_use_rt = 0; id_rs = 5'd7;
    cyc("lu_unused", O_NONE, 2'b00);

    // 2: load to r0 never stalls; taken branch suppresses load-use.
    ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1;
    cyc("lu_r0", O_NONE, 2'b00);
    ex_rd = 5'd9; id_rs = 5'd9; ex_br_taken = 1;
    cyc("br_over_lu", O_BR, 2'b00);
    idle_inputs();

    // 3: MDU with latency 4. mem_req during MDU must be ignored.
    ex_mdu_start = 1;
    cyc("mdu_entry", O_FREEZE, 2'b00);
    ex_mdu_start = 0; mem_req = 1;
    cyc("mdu_c2", O_FREEZE, 2'b01);
    cyc("mdu_c1", O_FREEZE, 2'b01);
    cyc("mdu_done", O_DONE, 2'b01);
    mem_req = 0;
    cyc("mdu_back", O_NONE, 2'b00);

    // Memory access completing in the same cycle needs no stall.
    mem_req = 1; mem_ready = 1;
    cyc("mem_fast", O_NONE, 2'b00);

    // 4: mem_ready low 5 cycles; branch in the entry cycle is held.
    mem_ready = 0; ex_br_taken = 1;
    cyc("mem_entry", O_FREEZE, 2'b00);
    ex_br_taken = 0;
    for (int i = 0; i < 4; i++) cyc("mem_wait", O_FREEZE, 2'b10);
    mem_ready = 1;
    cyc("mem_release", O_NONE, 2'b10);
    idle_inputs();
    cyc("mem_back", O_NONE, 2'b00);

    // 5: mem_ready never arrives -> timeout on the 15th MEM-state cycle.
    mem_req = 1;
    cyc("to_entry", O_FREEZE, 2'b00);
    for (int i = 0; i < 14; i++) cyc("to_wait", O_FREEZE, 2'b10);
    cyc("to_err", O_ERR, 2'b10);
    mem_req = 0;
    cyc("to_back", O_NONE, 2'b00);

    // 6: reset while MDU counter is 1 -> quiet outputs, RUN next, no done.
    ex_mdu_start = 1;
    cyc("rmdu_entry", O_FREEZE, 2'b00);
    ex_mdu_start = 0;
    cyc("rmdu_c2", O_FREEZE, 2'b01);
    rst = 1;
    #1;
    check("rmdu_rst outs", {4'b0, outs}, 16'h0000);
    @(negedge clk);
    rst = 0;
    cyc("rmdu_after", O_NONE, 2'b00);
    cyc("rmdu_quiet", O_NONE, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
